seg_scan_mux: RTL and testbench
===============================

// Module: seg_scan_mux
// PURPOSE
//  Downstream display stage after the FIFO read-side state machine (dataRDSM).
//  - Consumes each 16-bit word via a valid/ready handshake.
//  - Buffers one pending word.
//  - Time-multiplexes 4 hex digits onto one shared 7-seg bus (anodes scanned).
//  - Swaps in the new word only at a frame boundary, so a displayed value never tears.
// PARAMETERS
//  REFRESH_DIV  2500  clk cycles per digit slot (>=2); 10 MHz gives a 4 kHz digit rate
//  NUM_DIGITS   4     digits scanned; fixed at 4, data width = 4*NUM_DIGITS
// PORTS
//  clk         in   1   single clock (the read-domain clock, clk10)
//  rst         in   1   synchronous reset, active-high
//  data_in     in   16  word to display; digit0 = [3:0] (rightmost) .. digit3 = [15:12]
//  data_valid  in   1   data_in valid
//  data_ready  out  1   block can accept; equals !pend_full
//  an_n        out  4   digit enables, active-low, one-hot-low or all-high
//  seg         out  8   active-low segments {dp,g,f,e,d,c,b,a}
//  frame_tick  out  1   1-cycle pulse at the end of each full 4-digit scan
// BEHAVIOUR
//  Reset values
//  - an_n=4'hF, seg=8'hFF, data_ready=1, frame_tick=0.
//  - Internal: disp_reg=0, pend_full=0, idx=0, div=0, state IDLE.
//  Handshake
//  - Transfer occurs on a clk edge with data_valid & data_ready.
//  - Transfer writes pend_reg<=data_in and pend_full<=1.
//  - data_valid while !data_ready: ignored; the source must hold the word.
//  States
//  - IDLE: nothing displayed (an_n=F, seg=FF). When pend_full=1: disp_reg<=pend_reg,
//    pend_full<=0, idx<=0, div<=0, go to SCAN.
//  - SCAN: div counts 0..REFRESH_DIV-1, then wraps.
//    - On wrap: idx<=idx+1 mod 4.
//    - On wrap with idx==3: frame end; frame_tick=1 on the next cycle.
//    - If pend_full at frame end: disp_reg<=pend_reg, pend_full<=0.
//  - SCAN never returns to IDLE except via rst.
//  Outputs (all registered, 1-cycle latency from idx/div/disp_reg)
//  - Dead cycle: when div==0, an_n=F and seg=FF (anti-ghosting).
//  - Otherwise: an_n=~(4'b1<<idx), seg=LUT(disp_reg[4*idx+:4]), dp always off (seg[7]=1).
//  - LUT: 0=C0 1=F9 2=A4 3=B0 4=99 5=92 6=82 7=F8 8=80 9=90 A=88 B=83 C=C6 D=A1 E=86 F=8E.
//  Boundary cases
//  - Accept at the same edge as frame end: cannot happen (ready=0 while pend_full=1).
//  - Word accepted in the cycle right after a frame end waits one full frame.
//  - Back-to-back words: the second stalls (ready=0) until the next frame end.
//  - rst mid-frame: returns to IDLE and blanks the display the cycle after rst is sampled;
//    the pending word is discarded.
//  - div width: $clog2(REFRESH_DIV); no overflow past REFRESH_DIV-1.
// CONFIGURATION
//  SEG_LZ_BLANK_EN defined
//  - Leading-zero digits are blanked: seg=FF, an_n still scanned.
//  - Digit0 is never blanked; e.g. 16'h0040 shows "  40", 16'h0000 shows "   0".
//  SEG_LZ_BLANK_EN undefined: all 4 digits always shown; 16'h0040 shows "0040".
// STRUCTURE
//  - Package seg_pkg:
//    - SEG_LUT[16] constant;
//    - SEG_BLANK=8'hFF;
//    - scan state typedef {IDLE, SCAN}.
//  - One sub-module hex_seg_lut: combinational 4-bit to 8-bit active-low decode, used by the
//    output register stage.
// TESTING (REFRESH_DIV=4, so frame = 16 cycles)
//  1. Reset, no data: an_n=F, seg=FF, data_ready=1 for 50 cycles; frame_tick never pulses.
//  2. Send 16'h1234 -> SCAN; non-dead slots show an_n=E/seg=99, D/B0, B/A4, 7/F9;
//     frame_tick every 16 cycles.
//  3. Send 16'hABCD mid-frame, then 16'hEF01 at once:
//     - 16'hEF01 stalls (ready=0);
//     - 16'hABCD appears at the next frame end; 16'hEF01 accepted right after;
//     - 16'hEF01 shown one frame later.
//  4. Check every slot's first cycle: an_n=F, seg=FF.
//  5. With SEG_LZ_BLANK_EN: 16'h0040 gives digit3/digit2 seg=FF, digit1=99, digit0=C0;
//     without it all 4 show C0/C0/99/C0.
//  6. Assert rst for 1 cycle mid-frame with a word pending:
//     - next cycle an_n=F, data_ready=1;
//     - the pending word is never displayed.

Source files
------------

// File: rtl/seg_pkg.sv
// -----------------------------------------------------------------------------
// seg_pkg
//   Shared definitions for the 7-segment scan multiplexer:
//     SEG_LUT      - hex digit to active-low segment pattern {dp,g,f,e,d,c,b,a}
//     SEG_BLANK    - all segments off
//     scan_state_t - scan controller states
// -----------------------------------------------------------------------------
package seg_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // The decimal point (bit 7) is high in every entry, so dp is always off.
  localparam logic [7:0] SEG_LUT [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } scan_state_t;

endpackage

// File: rtl/hex_seg_lut.sv
// -----------------------------------------------------------------------------
// hex_seg_lut
//   Combinational hex-digit to 7-segment decoder (active-low outputs).
//   Ports:
//     nibble  in  4  hex digit value
//     seg     out 8  {dp,g,f,e,d,c,b,a}, active-low, dp always off
// -----------------------------------------------------------------------------
module hex_seg_lut
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] seg
);

  assign seg = SEG_LUT[nibble];

endmodule

// File: rtl/seg_scan_mux.sv
// -----------------------------------------------------------------------------
// seg_scan_mux
//   Display stage fed by a valid/ready source. Accepts 16-bit words into a
//   one-deep pending buffer and time-multiplexes the four hex digits of the
//   displayed word onto a shared 7-segment bus. A new word replaces the
//   displayed one only at the end of a full scan, so a frame never tears.
//
//   Parameters:
//     REFRESH_DIV  clk cycles per digit slot (>= 2)
//     NUM_DIGITS   digits scanned (4)
//   Ports:
//     clk         in   1   clock
//     rst         in   1   synchronous reset, active-high
//     data_in     in   16  word to display, digit0 = [3:0] (rightmost)
//     data_valid  in   1   data_in valid
//     data_ready  out  1   pending buffer empty, a word can be accepted
//     an_n        out  4   digit enables, active-low
//     seg         out  8   segments {dp,g,f,e,d,c,b,a}, active-low
//     frame_tick  out  1   one-cycle pulse at the end of each full scan
//
//   Build option:
//     SEG_LZ_BLANK_EN  when defined, leading-zero digits above digit0 are
//                      blanked (anodes still scanned).
// -----------------------------------------------------------------------------
module seg_scan_mux
  import seg_pkg::*;
#(
  parameter int REFRESH_DIV = 2500,
  parameter int NUM_DIGITS  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic                    data_valid,
  output logic                    data_ready,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic [7:0]              seg,
  output logic                    frame_tick
);

  localparam int DW     = 4 * NUM_DIGITS;
  localparam int DIV_W  = $clog2(REFRESH_DIV);
  localparam int IDX_W  = $clog2(NUM_DIGITS);
  localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  // State registers
  scan_state_t      state,     state_nxt;
  logic [IDX_W-1:0] idx,       idx_nxt;
  logic [DIV_W-1:0] div,       div_nxt;
  logic [DW-1:0]    disp_reg,  disp_nxt;
  logic [DW-1:0]    pend_reg,  pend_nxt;
  logic             pend_full, pend_full_nxt;

  // Registered-output next values
  logic [NUM_DIGITS-1:0] an_n_nxt;
  logic [7:0]            seg_nxt;
  logic                  frame_tick_nxt;

  logic       accept;
  logic       frame_end;
  logic [3:0] digit;
  logic [7:0] digit_seg;
  logic       slot_blank;
  logic       lz_blank;

  assign data_ready = !pend_full;
  assign accept     = data_valid && !pend_full;
  assign frame_end  = (state == SCAN) && (div == DIV_MAX) && (idx == IDX_LAST);
  assign digit      = disp_reg[{idx, 2'b00} +: 4];

  hex_seg_lut u_lut (
    .nibble (digit),
    .seg    (digit_seg)
  );

`ifdef SEG_LZ_BLANK_EN
  // A digit is a leading zero when it and every digit above it are zero.
  // Digit0 is exempt so a zero word still shows a single "0".
  logic [DW-1:0] upper_digits;
  assign upper_digits = disp_reg >> {idx, 2'b00};
  assign lz_blank     = (idx != '0) && (upper_digits == '0);
`else
  assign lz_blank = 1'b0;
`endif

  // The first cycle of every slot is dark so the previous digit's pattern
  // never flashes under the next anode while the bus settles.
  assign slot_blank = (state != SCAN) || (div == '0);

  // NOTE: every signal driven here gets a default before any branch; a path
  // that leaves one unassigned would infer a latch.
  always_comb begin
    state_nxt     = state;
    idx_nxt       = idx;
    div_nxt       = div;
    disp_nxt      = disp_reg;
    pend_nxt      = pend_reg;
    pend_full_nxt = pend_full;

    if (accept) begin
      pend_nxt      = data_in;
      pend_full_nxt = 1'b1;
    end

    unique case (state)
      IDLE: begin
        if (pend_full) begin
          disp_nxt      = pend_reg;
          pend_full_nxt = 1'b0;
          idx_nxt       = '0;
          div_nxt       = '0;
          state_nxt     = SCAN;
        end
      end
      SCAN: begin
        if (div == DIV_MAX) begin
          div_nxt = '0;
          idx_nxt = idx + 1'b1;
          // accept cannot coincide with this: it needs pend_full low.
          if (frame_end && pend_full) begin
            disp_nxt      = pend_reg;
            pend_full_nxt = 1'b0;
          end
        end else begin
          div_nxt = div + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    an_n_nxt       = '1;
    seg_nxt        = SEG_BLANK;
    frame_tick_nxt = frame_end;
    if (!slot_blank) begin
      an_n_nxt = ~(NUM_DIGITS'(1) << idx);
      seg_nxt  = lz_blank ? SEG_BLANK : digit_seg;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      div        <= '0;
      disp_reg   <= '0;
      pend_full  <= 1'b0;
      an_n       <= '1;
      seg        <= SEG_BLANK;
      frame_tick <= 1'b0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      div        <= div_nxt;
      disp_reg   <= disp_nxt;
      pend_full  <= pend_full_nxt;
      an_n       <= an_n_nxt;
      seg        <= seg_nxt;
      frame_tick <= frame_tick_nxt;
    end
  end

  // NOTE: pend_reg is pure datapath qualified by pend_full, so it carries no
  // reset; its content is never used while pend_full is low.
  always_ff @(posedge clk) begin
    pend_reg <= pend_nxt;
  end

endmodule

// File: tb/tb_seg_scan_mux.sv
// -----------------------------------------------------------------------------
// tb_seg_scan_mux
//   Self-checking bench for seg_scan_mux with REFRESH_DIV=4 (16-cycle frame).
//   Frame phase p: p=0 is the cycle frame_tick is high (last cycle of digit3),
//   p=1 is the dead cycle of digit0, digit k shows on p=4k+2..4k+4.
// -----------------------------------------------------------------------------
module tb_seg_scan_mux;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] data_in = '0;
  logic        data_valid = 1'b0;
  logic        data_ready;
  logic [3:0]  an_n;
  logic [7:0]  seg;
  logic        frame_tick;

  seg_scan_mux #(.REFRESH_DIV(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .an_n       (an_n),
    .seg        (seg),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int p        = 0;

  typedef struct {
    logic        valid;
    logic [15:0] data;
    logic [3:0]  an_n;
    logic [7:0]  seg;
    logic        tick;
    logic        ready;
  } vec_t;

  vec_t frame_tbl [16];

  task automatic tick();
    @(posedge clk);
    #1;
    p++;
  endtask

  task automatic goto_p(input int target);
    while (p < target) tick();
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp)
      $display("FAIL %s: got %h expected %h (p=%0d)", name, got, exp, p);
    else
      pass_cnt++;
  endtask

  // Compares {an_n, seg, frame_tick} in one go.
  task automatic check_disp(input string name, input logic [3:0] an, input logic [7:0] sg,
                            input logic tk);
    check(name, {19'd0, an_n, seg, frame_tick}, {19'd0, an, sg, tk});
  endtask

  task automatic check_idle(input string name);
    check(name, {18'd0, an_n, seg, frame_tick, data_ready}, {18'd0, 4'hF, 8'hFF, 1'b0, 1'b1});
  endtask

`ifdef SEG_LZ_BLANK_EN
  localparam logic [7:0] EXP_D2_0040 = 8'hFF;
  localparam logic [7:0] EXP_D3_0040 = 8'hFF;
`else
  localparam logic [7:0] EXP_D2_0040 = 8'hC0;
  localparam logic [7:0] EXP_D3_0040 = 8'hC0;
`endif

  initial begin
    int n;

    // One frame of 16'h1234 starting at p=1.
    frame_tbl[0]  = '{1'b0, 16'h0, 4'hF, 8'hFF, 1'b0, 1'b1};
    frame_tbl[1]  = '{1'b0, 16'h0, 4'hE, 8'h99, 1'b0, 1'b1};
    frame_tbl[2]  = '{1'b0, 16'h0, 4'hE, 8'h99, 1'b0, 1'b1};
    frame_tbl[3]  = '{1'b0, 16'h0, 4'hE, 8'h99, 1'b0, 1'b1};
    frame_tbl[4]  = '{1'b0, 16'h0, 4'hF, 8'hFF, 1'b0, 1'b1};
    frame_tbl[5]  = '{1'b0, 16'h0, 4'hD, 8'hB0, 1'b0, 1'b1};
    frame_tbl[6]  = '{1'b0, 16'h0, 4'hD, 8'hB0, 1'b0, 1'b1};
    frame_tbl[7]  = '{1'b0, 16'h0, 4'hD, 8'hB0, 1'b0, 1'b1};
    frame_tbl[8]  = '{1'b0, 16'h0, 4'hF, 8'hFF, 1'b0, 1'b1};
    frame_tbl[9]  = '{1'b0, 16'h0, 4'hB, 8'hA4, 1'b0, 1'b1};
    frame_tbl[10] = '{1'b0, 16'h0, 4'hB, 8'hA4, 1'b0, 1'b1};
    frame_tbl[11] = '{1'b0, 16'h0, 4'hB, 8'hA4, 1'b0, 1'b1};
    frame_tbl[12] = '{1'b0, 16'h0, 4'hF, 8'hFF, 1'b0, 1'b1};
    frame_tbl[13] = '{1'b0, 16'h0, 4'h7, 8'hF9, 1'b0, 1'b1};
    frame_tbl[14] = '{1'b0, 16'h0, 4'h7, 8'hF9, 1'b0, 1'b1};
    frame_tbl[15] = '{1'b0, 16'h0, 4'h7, 8'hF9, 1'b1, 1'b1};

    // 1. Reset, then idle with no data.
    tick();
    tick();
    check_idle("reset_state");
    rst = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      check_idle("idle_no_data");
    end

    // 2. Send 16'h1234 and sync to its first frame end.
    data_in    = 16'h1234;
    data_valid = 1'b1;
    tick();
    check("accept_1234_ready", {31'd0, data_ready}, 32'd0);
    data_valid = 1'b0;
    n = 0;
    while (!frame_tick && n < 40) begin
      tick();
      n++;
    end
    check("first_tick_latency", n, 32'd17);
    p = 0;
    for (int i = 0; i < 16; i++) begin
      data_valid = frame_tbl[i].valid;
      data_in    = frame_tbl[i].data;
      tick();
      check_disp($sformatf("frame_1234[%0d]", i), frame_tbl[i].an_n, frame_tbl[i].seg,
                 frame_tbl[i].tick);
      check($sformatf("frame_1234_ready[%0d]", i), {31'd0, data_ready},
            {31'd0, frame_tbl[i].ready});
    end

    // 3. 16'hABCD mid-frame, 16'hEF01 immediately after (stalls).
    p = 0;
    goto_p(5);
    data_in    = 16'hABCD;
    data_valid = 1'b1;
    tick();
    check("abcd_accepted", {31'd0, data_ready}, 32'd0);
    data_in = 16'hEF01;
    goto_p(15);
    check("ef01_stalled", {31'd0, data_ready}, 32'd0);
    check_disp("old_word_before_end", 4'h7, 8'hF9, 1'b0);
    tick();
    check_disp("frame_end_no_tear", 4'h7, 8'hF9, 1'b1);
    check("ready_after_swap", {31'd0, data_ready}, 32'd1);
    tick();
    check("ef01_accepted", {31'd0, data_ready}, 32'd0);
    data_valid = 1'b0;
    check_disp("tick_one_cycle", 4'hF, 8'hFF, 1'b0);

    // 4. Dead cycles and 16'hABCD digits.
    goto_p(19); check_disp("abcd_d0", 4'hE, 8'hA1, 1'b0);
    goto_p(21); check_disp("dead_slot1", 4'hF, 8'hFF, 1'b0);
    goto_p(23); check_disp("abcd_d1", 4'hD, 8'hC6, 1'b0);
    goto_p(25); check_disp("dead_slot2", 4'hF, 8'hFF, 1'b0);
    goto_p(27); check_disp("abcd_d2", 4'hB, 8'h83, 1'b0);
    goto_p(29); check_disp("dead_slot3", 4'hF, 8'hFF, 1'b0);
    goto_p(31); check_disp("abcd_d3", 4'h7, 8'h88, 1'b0);
    goto_p(32); check_disp("abcd_frame_end", 4'h7, 8'h88, 1'b1);
    goto_p(33); check_disp("dead_slot0", 4'hF, 8'hFF, 1'b0);
    goto_p(35); check_disp("ef01_d0", 4'hE, 8'hF9, 1'b0);
    goto_p(39); check_disp("ef01_d1", 4'hD, 8'hC0, 1'b0);
    goto_p(43); check_disp("ef01_d2", 4'hB, 8'h8E, 1'b0);
    goto_p(47); check_disp("ef01_d3", 4'h7, 8'h86, 1'b0);

    // 5. 16'h0040 accepted right after a frame end waits a full frame.
    goto_p(48);
    check_disp("ef01_frame_end", 4'h7, 8'h86, 1'b1);
    data_in    = 16'h0040;
    data_valid = 1'b1;
    tick();
    check("accept_0040_ready", {31'd0, data_ready}, 32'd0);
    data_valid = 1'b0;
    goto_p(51); check_disp("0040_waits", 4'hE, 8'hF9, 1'b0);
    goto_p(64); check_disp("0040_swap_end", 4'h7, 8'h86, 1'b1);
    goto_p(67); check_disp("0040_d0", 4'hE, 8'hC0, 1'b0);
    goto_p(71); check_disp("0040_d1", 4'hD, 8'h99, 1'b0);
    goto_p(75); check_disp("0040_d2", 4'hB, EXP_D2_0040, 1'b0);
    goto_p(79); check_disp("0040_d3", 4'h7, EXP_D3_0040, 1'b0);

    // 6. Reset mid-frame with a word pending.
    goto_p(81);
    data_in    = 16'h5678;
    data_valid = 1'b1;
    tick();
    check("accept_5678_ready", {31'd0, data_ready}, 32'd0);
    data_valid = 1'b0;
    goto_p(85);
    rst = 1'b1;
    tick();
    check_idle("rst_mid_frame");
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      check_idle("pending_discarded");
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
